worddata_entry: RTL and testbench

Push-button/switch word-entry block for the DE0 monitor. It is the input-side counterpart of the 7-segment word display: the operator keys a 32-bit word in one hex nibble at a time from four slide switches and then commits it. The committed word is offered to the monitor on a valid/ready handshake. The live entry register is exported so the existing display path can echo it while it is being typed.

---
 rtl/worddata_entry.sv | 168 ++++++++++++++++
 tb/tb_worddata_entry.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/worddata_entry.sv
// worddata_entry
// Push-button / slide-switch word entry for the DE0 monitor. The operator
// keys a 32-bit word in one hex nibble at a time and then commits it. The
// committed word is offered on a valid/ready handshake. The live entry
// register is exported so the display path can echo it while it is typed.
//
// Ports:
//   clk           system clock
//   reset_n       asynchronous active-low reset
//   sw_nibble     hex digit to shift in (asynchronous slide switches)
//   btn_shift_n   active-low push button: shift digit in
//   btn_commit_n  active-low push button: commit word
//   btn_clear_n   active-low push button: clear / abort
//   entry_word    live entry register
//   nibble_count  nibbles entered since last clear (0..8)
//   word_data     committed word, stable while word_valid=1
//   word_valid    committed word offered
//   word_ready    monitor accepts word_data
module worddata_entry #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  sw_nibble,
  input  logic        btn_shift_n,
  input  logic        btn_commit_n,
  input  logic        btn_clear_n,
  output logic [31:0] entry_word,
  output logic [3:0]  nibble_count,
  output logic [31:0] word_data,
  output logic        word_valid,
  input  logic        word_ready
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Button order: bit 0 shift, bit 1 commit, bit 2 clear.
  logic [2:0] btn_raw;
  logic [2:0] press_evt;

  assign btn_raw = {btn_clear_n, btn_commit_n, btn_shift_n};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_btn
      logic             sync1_reg;
      logic             sync2_reg;
      logic             stable_reg;
      logic [CNT_W-1:0] cnt_reg;
      logic             press_reg;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          sync1_reg  <= 1'b1;
          sync2_reg  <= 1'b1;
          stable_reg <= 1'b1;
          cnt_reg    <= '0;
          press_reg  <= 1'b0;
        end else begin
          sync1_reg <= btn_raw[gi];
          sync2_reg <= sync1_reg;
          press_reg <= 1'b0;
          if (sync2_reg == stable_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_MAX) begin
            stable_reg <= sync2_reg;
            cnt_reg    <= '0;
            // Only the 1->0 transition is a press; a release leaves it low.
            press_reg  <= stable_reg;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign press_evt[gi] = press_reg;
    end
  endgenerate

  logic shift_evt, commit_evt, clear_evt;
  assign shift_evt  = press_evt[0];
  assign commit_evt = press_evt[1];
  assign clear_evt  = press_evt[2];

  // Switch synchronizer; value is used in the cycle a shift event applies.
  logic [3:0] sw_sync1_reg, sw_sync2_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_sync1_reg <= '0;
      sw_sync2_reg <= '0;
    end else begin
      sw_sync1_reg <= sw_nibble;
      sw_sync2_reg <= sw_sync1_reg;
    end
  end

  typedef enum logic {EDIT = 1'b0, OFFER = 1'b1} state_t;

  state_t      state_reg, state_next;
  logic [31:0] entry_word_reg, entry_word_next;
  logic [3:0]  nibble_count_reg, nibble_count_next;
  logic [31:0] word_data_reg, word_data_next;
  logic        word_valid_reg, word_valid_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= EDIT;
      entry_word_reg   <= '0;
      nibble_count_reg <= '0;
      word_data_reg    <= '0;
      word_valid_reg   <= 1'b0;
    end else begin
      state_reg        <= state_next;
      entry_word_reg   <= entry_word_next;
      nibble_count_reg <= nibble_count_next;
      word_data_reg    <= word_data_next;
      word_valid_reg   <= word_valid_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    entry_word_next   = entry_word_reg;
    nibble_count_next = nibble_count_reg;
    word_data_next    = word_data_reg;
    word_valid_next   = word_valid_reg;

    unique case (state_reg)
      EDIT: begin
        // Priority clear > commit > shift; lower events in the cycle drop,
        // including a shift coinciding with an ignored empty commit.
        if (clear_evt) begin
          entry_word_next   = '0;
          nibble_count_next = '0;
        end else if (commit_evt) begin
          if (nibble_count_reg != 4'd0) begin
            word_data_next  = entry_word_reg;
            word_valid_next = 1'b1;
            state_next      = OFFER;
          end
        end else if (shift_evt) begin
          entry_word_next   = {entry_word_reg[27:0], sw_sync2_reg};
          nibble_count_next = (nibble_count_reg == 4'd8) ? 4'd8
                                                         : nibble_count_reg + 4'd1;
        end
      end
      OFFER: begin
        // Transfer and abort look identical at the outputs; word_data is
        // left alone so the monitor's last view of it stays intact.
        if (word_ready || clear_evt) begin
          word_valid_next   = 1'b0;
          entry_word_next   = '0;
          nibble_count_next = '0;
          state_next        = EDIT;
        end
      end
      default: state_next = EDIT;
    endcase
  end

  assign entry_word   = entry_word_reg;
  assign nibble_count = nibble_count_reg;
  assign word_data    = word_data_reg;
  assign word_valid   = word_valid_reg;

endmodule

// File: tb/tb_worddata_entry.sv
// Directed bench for worddata_entry with DEBOUNCE_CYCLES=4.
module tb_worddata_entry;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  sw_nibble;
  logic [2:0]  btn_n;  // {clear, commit, shift}
  logic [31:0] entry_word;
  logic [3:0]  nibble_count;
  logic [31:0] word_data;
  logic        word_valid;
  logic        word_ready;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  worddata_entry #(.DEBOUNCE_CYCLES(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sw_nibble    (sw_nibble),
    .btn_shift_n  (btn_n[0]),
    .btn_commit_n (btn_n[1]),
    .btn_clear_n  (btn_n[2]),
    .entry_word   (entry_word),
    .nibble_count (nibble_count),
    .word_data    (word_data),
    .word_valid   (word_valid),
    .word_ready   (word_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    $display("vector %0d %s: observed 0x%08h expected 0x%08h", vectors, tag, obs, exp);
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Hold the selected buttons low long enough to debounce, then release
  // and wait out the release debounce.
  task automatic press(input logic [2:0] mask);
    @(negedge clk);
    btn_n = btn_n & ~mask;
    repeat (6) @(negedge clk);
    btn_n = 3'b111;
    repeat (12) @(negedge clk);
  endtask

  task automatic shift_in(input logic [3:0] d);
    @(negedge clk);
    sw_nibble = d;
    press(3'b001);
  endtask

  initial begin
    reset_n    = 1'b0;
    sw_nibble  = 4'h0;
    btn_n      = 3'b111;
    word_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_entry", entry_word, 32'h0);
    check("rst_count", {28'h0, nibble_count}, 32'h0);
    check("rst_data", word_data, 32'h0);
    check("rst_valid", {31'h0, word_valid}, 32'h0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // Entry and commit
    shift_in(4'h1);
    check("shift1_entry", entry_word, 32'h1);
    shift_in(4'h2);
    shift_in(4'hA);
    check("shift3_entry", entry_word, 32'h0000012A);
    check("shift3_count", {28'h0, nibble_count}, 32'h3);
    press(3'b010);
    check("commit_valid", {31'h0, word_valid}, 32'h1);
    check("commit_data", word_data, 32'h0000012A);
    check("commit_entry", entry_word, 32'h0000012A);
    check("commit_count", {28'h0, nibble_count}, 32'h3);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("hold_data", word_data, 32'h0000012A);
    end
    check("hold_valid", {31'h0, word_valid}, 32'h1);

    // Shift during OFFER is discarded
    shift_in(4'h5);
    check("offer_shift_data", word_data, 32'h0000012A);
    check("offer_shift_entry", entry_word, 32'h0000012A);
    check("offer_shift_valid", {31'h0, word_valid}, 32'h1);

    // Handshake
    @(negedge clk);
    word_ready = 1'b1;
    @(negedge clk);
    word_ready = 1'b0;
    check("ready_valid", {31'h0, word_valid}, 32'h0);
    check("ready_entry", entry_word, 32'h0);
    check("ready_count", {28'h0, nibble_count}, 32'h0);

    // Commit with nothing entered
    press(3'b010);
    check("empty_commit_valid", {31'h0, word_valid}, 32'h0);
    check("empty_commit_data", word_data, 32'h0000012A);

    // Overflow: nine nibbles
    for (int n = 1; n <= 9; n++) shift_in(4'(n));
    check("ovf_entry", entry_word, 32'h23456789);
    check("ovf_count", {28'h0, nibble_count}, 32'h8);

    // Bounce shorter than debounce window
    sw_nibble = 4'hB;
    @(negedge clk);
    btn_n[0] = 1'b0;
    repeat (3) @(negedge clk);
    btn_n[0] = 1'b1;
    repeat (12) @(negedge clk);
    check("bounce_entry", entry_word, 32'h23456789);

    // Latency: event applied at edge k+6
    @(negedge clk);
    btn_n[0] = 1'b0;
    @(posedge clk);              // edge k
    repeat (5) @(posedge clk);   // edge k+5
    @(negedge clk);
    check("lat_before", entry_word, 32'h23456789);
    @(posedge clk);              // edge k+6
    @(negedge clk);
    check("lat_after", entry_word, 32'h3456789B);
    repeat (4) @(negedge clk);
    btn_n[0] = 1'b1;
    repeat (12) @(negedge clk);
    check("lat_once_entry", entry_word, 32'h3456789B);
    check("lat_once_count", {28'h0, nibble_count}, 32'h8);

    // Clear, then clear+commit aligned at count 2
    press(3'b100);
    check("clear_entry", entry_word, 32'h0);
    check("clear_count", {28'h0, nibble_count}, 32'h0);
    shift_in(4'h1);
    shift_in(4'h2);
    check("pre_cc_count", {28'h0, nibble_count}, 32'h2);
    press(3'b110);
    check("cc_entry", entry_word, 32'h0);
    check("cc_count", {28'h0, nibble_count}, 32'h0);
    check("cc_valid", {31'h0, word_valid}, 32'h0);

    // Abort during OFFER
    shift_in(4'hC);
    press(3'b010);
    check("abort_pre_valid", {31'h0, word_valid}, 32'h1);
    check("abort_pre_data", word_data, 32'h0000000C);
    press(3'b100);
    check("abort_valid", {31'h0, word_valid}, 32'h0);
    check("abort_data", word_data, 32'h0000000C);
    check("abort_entry", entry_word, 32'h0);
    shift_in(4'hD);
    check("edit_after_abort", entry_word, 32'h0000000D);
    press(3'b010);
    check("reoffer_valid", {31'h0, word_valid}, 32'h1);
    check("reoffer_data", word_data, 32'h0000000D);

    // Asynchronous reset in the middle of a cycle
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_entry", entry_word, 32'h0);
    check("arst_count", {28'h0, nibble_count}, 32'h0);
    check("arst_data", word_data, 32'h0);
    check("arst_valid", {31'h0, word_valid}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
